// File: rtl/mbist_march_y_ctrl.sv
// March Y memory BIST controller: sequences {<>(w0); ^(r0,w1,r1); v(r1,w0,r0); <>(r0)}
// one memory op per clock and compares read data one cycle after each read.
module mbist_march_y_ctrl #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] CA,
    output logic              we,
    output logic              re,
    output logic [DATA_W-1:0] datain,
    input  logic [DATA_W-1:0] dataout,
    output logic              busy,
    output logic              done,
    output logic              fail,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [1:0]        fail_elem,
    output logic [7:0]        err_count
);

    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
    localparam logic [ADDR_W-1:0] ADDR_MIN = '0;
    localparam logic [DATA_W-1:0] PAT_ZERO = '0;
    localparam logic [DATA_W-1:0] PAT_ONES = '1;
    localparam logic [7:0]        ERR_MAX  = 8'hFF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_M0,
        S_M1,
        S_M2,
        S_M3,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t            state, state_n;
    logic [1:0]        phase, phase_n;
    logic [ADDR_W-1:0] ca_n;
    logic              we_n, re_n;
    logic [DATA_W-1:0] datain_n;
    logic              busy_n, done_n, fail_n;
    logic [ADDR_W-1:0] fail_addr_n;
    logic [1:0]        fail_elem_n;
    logic [7:0]        err_count_n;

    logic              cmp_valid, cmp_valid_n;
    logic [DATA_W-1:0] cmp_exp, cmp_exp_n;
    logic [ADDR_W-1:0] cmp_addr, cmp_addr_n;
    logic [1:0]        cmp_elem, cmp_elem_n;

    logic [DATA_W-1:0] rd_exp_c;
    logic [1:0]        rd_elem_c;
    logic              mismatch_c;

    // Expected word and element of the read currently on the bus
    always_comb begin
        rd_exp_c  = PAT_ZERO;
        rd_elem_c = 2'd0;
        case (state)
            S_M1: begin
                rd_elem_c = 2'd1;
                rd_exp_c  = (phase == 2'd2) ? PAT_ONES : PAT_ZERO;
            end
            S_M2: begin
                rd_elem_c = 2'd2;
                rd_exp_c  = (phase == 2'd0) ? PAT_ONES : PAT_ZERO;
            end
            S_M3: begin
                rd_elem_c = 2'd3;
                rd_exp_c  = PAT_ZERO;
            end
            default: begin
                rd_elem_c = 2'd0;
                rd_exp_c  = PAT_ZERO;
            end
        endcase
    end

    assign mismatch_c = cmp_valid && (dataout != cmp_exp);

    // Next-state, next-op and result logic
    always_comb begin
        state_n     = state;
        phase_n     = phase;
        ca_n        = CA;
        we_n        = 1'b0;
        re_n        = 1'b0;
        datain_n    = datain;
        busy_n      = busy;
        done_n      = done;
        fail_n      = fail;
        fail_addr_n = fail_addr;
        fail_elem_n = fail_elem;
        err_count_n = err_count;
        cmp_valid_n = re;
        cmp_exp_n   = rd_exp_c;
        cmp_addr_n  = CA;
        cmp_elem_n  = rd_elem_c;

        if (mismatch_c) begin
            fail_n = 1'b1;
            if (!fail) begin
                fail_addr_n = cmp_addr;
                fail_elem_n = cmp_elem;
            end
            if (err_count != ERR_MAX) begin
                err_count_n = err_count + 8'd1;
            end
        end

        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_n     = S_M0;
                    phase_n     = 2'd0;
                    ca_n        = ADDR_MIN;
                    we_n        = 1'b1;
                    datain_n    = PAT_ZERO;
                    busy_n      = 1'b1;
                    done_n      = 1'b0;
                    fail_n      = 1'b0;
                    fail_addr_n = '0;
                    fail_elem_n = 2'd0;
                    err_count_n = 8'd0;
                end
            end
            S_M0: begin
                if (CA == ADDR_MAX) begin
                    state_n = S_M1;
                    ca_n    = ADDR_MIN;
                    phase_n = 2'd0;
                    re_n    = 1'b1;
                end else begin
                    ca_n     = CA + ADDR_W'(1);
                    we_n     = 1'b1;
                    datain_n = PAT_ZERO;
                end
            end
            S_M1: begin
                case (phase)
                    2'd0: begin
                        phase_n  = 2'd1;
                        we_n     = 1'b1;
                        datain_n = PAT_ONES;
                    end
                    2'd1: begin
                        phase_n = 2'd2;
                        re_n    = 1'b1;
                    end
                    default: begin
                        phase_n = 2'd0;
                        re_n    = 1'b1;
                        if (CA == ADDR_MAX) begin
                            state_n = S_M2;
                        end else begin
                            ca_n = CA + ADDR_W'(1);
                        end
                    end
                endcase
            end
            S_M2: begin
                case (phase)
                    2'd0: begin
                        phase_n  = 2'd1;
                        we_n     = 1'b1;
                        datain_n = PAT_ZERO;
                    end
                    2'd1: begin
                        phase_n = 2'd2;
                        re_n    = 1'b1;
                    end
                    default: begin
                        phase_n = 2'd0;
                        re_n    = 1'b1;
                        if (CA == ADDR_MIN) begin
                            state_n = S_M3;
                        end else begin
                            ca_n = CA - ADDR_W'(1);
                        end
                    end
                endcase
            end
            S_M3: begin
                if (CA == ADDR_MAX) begin
                    state_n = S_DRAIN;
                end else begin
                    ca_n = CA + ADDR_W'(1);
                    re_n = 1'b1;
                end
            end
            S_DRAIN: begin
                state_n = S_DONE;
                busy_n  = 1'b0;
                done_n  = 1'b1;
            end
            default: begin
                state_n = S_IDLE;
                busy_n  = 1'b0;
                done_n  = 1'b0;
            end
        endcase
    end

    // State, op and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            phase     <= 2'd0;
            CA        <= '0;
            we        <= 1'b0;
            re        <= 1'b0;
            datain    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            fail      <= 1'b0;
            fail_addr <= '0;
            fail_elem <= 2'd0;
            err_count <= 8'd0;
            cmp_valid <= 1'b0;
            cmp_exp   <= '0;
            cmp_addr  <= '0;
            cmp_elem  <= 2'd0;
        end else begin
            state     <= state_n;
            phase     <= phase_n;
            CA        <= ca_n;
            we        <= we_n;
            re        <= re_n;
            datain    <= datain_n;
            busy      <= busy_n;
            done      <= done_n;
            fail      <= fail_n;
            fail_addr <= fail_addr_n;
            fail_elem <= fail_elem_n;
            err_count <= err_count_n;
            cmp_valid <= cmp_valid_n;
            cmp_exp   <= cmp_exp_n;
            cmp_addr  <= cmp_addr_n;
            cmp_elem  <= cmp_elem_n;
        end
    end

endmodule

// File: tb/tb_mbist_march_y_ctrl.sv
// Bench for mbist_march_y_ctrl: 16x8 memory with injectable stuck-at faults and a
// march-level reference model giving the expected op sequence and final results.
module tb_mbist_march_y_ctrl;

    localparam int unsigned AW    = 4;
    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned NOPS  = 8 * DEPTH;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] CA;
    logic          we;
    logic          re;
    logic [DW-1:0] datain;
    logic [DW-1:0] dataout;
    logic          busy;
    logic          done;
    logic          fail;
    logic [AW-1:0] fail_addr;
    logic [1:0]    fail_elem;
    logic [7:0]    err_count;

    mbist_march_y_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .start(start),
        .CA(CA), .we(we), .re(re), .datain(datain), .dataout(dataout),
        .busy(busy), .done(done), .fail(fail), .fail_addr(fail_addr),
        .fail_elem(fail_elem), .err_count(err_count)
    );

    always #5 clk = ~clk;

    // Test memory: reads return the stored word through per-address stuck-at masks
    logic [DW-1:0] mem   [DEPTH];
    logic [DW-1:0] and_m [DEPTH];
    logic [DW-1:0] or_m  [DEPTH];

    always @(posedge clk) begin
        if (we) mem[CA] <= datain;
        if (re) dataout <= (mem[CA] & and_m[CA]) | or_m[CA];
    end

    typedef struct packed {
        logic          we;
        logic          re;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } op_t;

    op_t           ops[$];
    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] last_d;
    logic          m_fail;
    logic [AW-1:0] m_addr;
    logic [1:0]    m_elem;
    int            m_cnt;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ref_wr(input int a, input logic [DW-1:0] d);
        op_t o;
        o.we = 1'b1; o.re = 1'b0; o.a = AW'(a); o.d = d;
        ops.push_back(o);
        ref_mem[a] = d;
        last_d     = d;
    endtask

    task automatic ref_rd(input int a, input logic [DW-1:0] e, input int el);
        op_t o;
        logic [DW-1:0] seen;
        o.we = 1'b0; o.re = 1'b1; o.a = AW'(a); o.d = last_d;
        ops.push_back(o);
        seen = (ref_mem[a] & and_m[a]) | or_m[a];
        if (seen !== e) begin
            if (!m_fail) begin
                m_addr = AW'(a);
                m_elem = 2'(el);
            end
            m_fail = 1'b1;
            if (m_cnt < 255) m_cnt++;
        end
    endtask

    // March Y walked element by element over an array memory
    task automatic build_ref();
        ops.delete();
        m_fail = 1'b0; m_addr = '0; m_elem = 2'd0; m_cnt = 0; last_d = '0;
        for (int a = 0; a < DEPTH; a++) ref_wr(a, 8'h00);
        for (int a = 0; a < DEPTH; a++) begin
            ref_rd(a, 8'h00, 1); ref_wr(a, 8'hFF); ref_rd(a, 8'hFF, 1);
        end
        for (int a = DEPTH - 1; a >= 0; a--) begin
            ref_rd(a, 8'hFF, 2); ref_wr(a, 8'h00); ref_rd(a, 8'h00, 2);
        end
        for (int a = 0; a < DEPTH; a++) ref_rd(a, 8'h00, 3);
    endtask

    task automatic clear_faults();
        for (int a = 0; a < DEPTH; a++) begin
            and_m[a] = '1;
            or_m[a]  = '0;
        end
    endtask

    // One full run from an accepted start, checking every op cycle and the results
    task automatic run(input bit poke_start);
        op_t o;
        build_ref();
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
        chk("clr_fail", 32'(fail), 32'(0));
        chk("clr_err", 32'(err_count), 32'(0));
        chk("clr_done", 32'(done), 32'(0));
        for (int c = 1; c <= NOPS; c++) begin
            cyc = c;
            o = ops[c-1];
            chk("op", 32'({busy, done, we, re, CA, datain}),
                32'({1'b1, 1'b0, o.we, o.re, o.a, o.d}));
            start = (poke_start && $urandom_range(0, 5) == 0) ? 1'b1 : 1'b0;
            tick();
        end
        start = 1'b0;
        cyc = NOPS + 1;
        chk("drain", 32'({busy, done, we, re}), 32'(4'b1000));
        tick();
        cyc = NOPS + 2;
        chk("done", 32'({busy, done, we, re}), 32'(4'b0100));
        chk("fail", 32'(fail), 32'(m_fail));
        chk("fail_addr", 32'(fail_addr), 32'(m_addr));
        chk("fail_elem", 32'(fail_elem), 32'(m_elem));
        chk("err_count", 32'(err_count), 32'(m_cnt));
        tick();
        chk("done_hold", 32'({busy, done}), 32'(2'b01));
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        clear_faults();
        tick();
        tick();
        // start coinciding with reset must be ignored
        start = 1'b1;
        tick();
        chk("reset_all", 32'({CA, we, re, datain, busy, done, fail, fail_addr, fail_elem, err_count}), 32'(0));
        rst = 1'b0;
        start = 1'b0;
        tick();
        chk("idle_after_rst", 32'({busy, done, we, re}), 32'(0));
        tick();

        // fault-free run, then directed stuck-at cases restarted from DONE
        run(1'b0);
        clear_faults();
        and_m[5] = 8'h00;
        run(1'b1);
        chk("sa0_addr5", 32'({fail, fail_addr, fail_elem, err_count}),
            32'({1'b1, 4'd5, 2'd1, 8'd2}));
        clear_faults();
        or_m[9] = 8'hFF;
        run(1'b0);
        chk("sa1_addr9", 32'({fail, fail_addr, fail_elem, err_count}),
            32'({1'b1, 4'd9, 2'd1, 8'd3}));

        // random single- and multi-bit stuck faults
        for (int r = 0; r < 4; r++) begin
            clear_faults();
            for (int i = 0; i <= int'($urandom_range(0, 2)); i++) begin
                int unsigned a;
                logic [DW-1:0] bits;
                a = $urandom_range(0, DEPTH - 1);
                bits = DW'($urandom_range(1, 255));
                if ($urandom_range(0, 1) == 0) and_m[a] = and_m[a] & ~bits;
                else or_m[a] = or_m[a] | bits;
            end
            run(1'b1);
        end

        // reset in the middle of M1, then a clean rerun
        clear_faults();
        or_m[3] = 8'h01;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 40; c++) tick();
        cyc = 40;
        chk("midrun_busy", 32'({busy, done}), 32'(2'b10));
        rst = 1'b1;
        start = 1'b1;
        tick();
        cyc = 41;
        chk("midrun_reset", 32'({CA, we, re, datain, busy, done, fail, fail_addr, fail_elem, err_count}), 32'(0));
        rst = 1'b0;
        start = 1'b0;
        tick();
        chk("midrun_idle", 32'({busy, done, we, re, fail, err_count}), 32'(0));
        clear_faults();
        run(1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
